regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32: register width in bits.
REQ-002 SHALL provide parameter NREGS, default 32: register count, power of two >= 2; AW = log2(NREGS).
REQ-003 SHALL provide parameter NRD, default 2: number of read ports.
REQ-004 SHALL provide parameter NWR, default 1: number of write ports.
REQ-005 SHALL provide parameter SYNC_READ, default 0: 0 means combinational read, 1 means registered read.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port rd_addr, input, NRD x AW: read addresses.
REQ-009 SHALL have port rd_data, output, NRD x XLEN: read data.
REQ-010 SHALL have port rd_busy, output, NRD: the addressed register has a pending write.
REQ-011 SHALL have port wr_en, input, NWR: write enables.
REQ-012 SHALL have port wr_addr, input, NWR x AW: write addresses.
REQ-013 SHALL have port wr_data, input, NWR x XLEN: write data.
REQ-014 SHALL have port rsv_en, input, 1 bit: reserve a destination register at issue.
REQ-015 SHALL have port rsv_addr, input, AW: the register to reserve.
REQ-016 SHALL have port flush, input, 1 bit: clear all reservations.

Function
REQ-017 SHALL return zero for register 0 on every read port; writes to and reservations of register 0 are ignored.
REQ-018 SHALL update the register at wr_addr[i] with wr_data[i] on the clock edge when wr_en[i]=1.
REQ-019 SHALL apply the highest-indexed port's data when several enabled write ports target the same address in one cycle.
REQ-020 SHALL, when SYNC_READ=0, drive rd_data[j] combinationally and write-first: if a same-cycle enabled write targets rd_addr[j] (nonzero), output that write's data, using the REQ-019 priority.
REQ-021 SHALL, when SYNC_READ=1, register rd_data[j] with 1-cycle latency: rd_addr is sampled at edge N, data is valid after edge N, and the REQ-020 bypass applies to writes in the sampling cycle.
REQ-022 SHALL hold one pending bit per register; reserving sets the bit at the next edge.
REQ-023 SHALL clear a register's pending bit at the edge of any enabled write to that register.
REQ-024 SHALL give reserve priority over clear when a reserve and a write hit the same register in one cycle, leaving the bit set (new producer).
REQ-025 SHALL clear every pending bit at the next edge when flush=1, with priority over same-cycle rsv_en.
REQ-026 SHALL drive rd_busy[j] combinationally as pending[rd_addr[j]] AND NOT (any same-cycle enabled write to rd_addr[j]); rd_busy for register 0 is always 0.
REQ-027 SHALL align rd_busy with rd_data when SYNC_READ=1, registering it in the same way.

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear all registers, all pending bits and the registered rd_data/rd_busy to zero.
REQ-029 SHALL in combinational mode output rd_data=0 and rd_busy=0 during reset.
REQ-030 SHALL discard any write, reserve or flush in progress when reset asserts mid-operation; no state survives.
REQ-031 SHALL accept new operations at the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL take default XLEN and NREGS constants and an AW-wide register-index typedef from shared package regfile_pkg.
REQ-033 SHALL place the pending-bit logic (REQ-022..026) in sub-module regfile_scoreboard.
REQ-034 SHALL generate read and write ports with generate loops; no port-count-specific code.

Verification
REQ-035 SHALL cover x0 protection: write 0xDEADBEEF to register 0, then read register 0 -> rd_data=0.
REQ-036 SHALL cover combinational bypass (SYNC_READ=0): write register 5 = 0x12345678 while reading register 5 in the same cycle -> rd_data=0x12345678 that cycle.
REQ-037 SHALL cover write collision (NWR=2): both ports write register 7 (0x11, 0x22) -> register 7 reads 0x22.
REQ-038 SHALL cover scoreboard priority: reserve register 3 -> rd_busy=1; write 3 with reserve 3 in the same cycle -> rd_busy stays 1; a later write to 3 alone -> rd_busy=0.
REQ-039 SHALL cover flush: reserve registers 4 and 9, then flush with rsv_addr=10 -> all rd_busy=0 next cycle, including register 10.
REQ-040 SHALL cover registered read (SYNC_READ=1): address 6 sampled at edge N with a same-cycle write of 0xA5 -> rd_data=0xA5 after edge N; assert rst_n mid-run -> rd_data=0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the register-index type for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by write or flush.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  input  logic                    flush,
  output logic [NRD-1:0]          rd_busy
);

  logic [NREGS-1:0] pending;

  // Register 0 can never be reserved, so its bit is a constant zero.
  assign pending[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_pend
      logic pending_reg;
      logic pending_next;
      logic wr_hit;

      always_comb begin
        wr_hit = 1'b0;
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_addr[k] == AW'(gi))) wr_hit = 1'b1;
        end
      end

      // Flush beats reserve; a reserve beats a same-cycle write (new producer).
      always_comb begin
        pending_next = pending_reg;
        if (flush)
          pending_next = 1'b0;
        else if (rsv_en && (rsv_addr == AW'(gi)))
          pending_next = 1'b1;
        else if (wr_hit)
          pending_next = 1'b0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_reg <= 1'b0;
        else        pending_reg <= pending_next;
      end

      assign pending[gi] = pending_reg;
    end

    for (gi = 0; gi < NRD; gi++) begin : g_busy
      logic rd_hit;

      always_comb begin
        rd_hit = 1'b0;
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_addr[k] == rd_addr[gi])) rd_hit = 1'b1;
        end
      end

      assign rd_busy[gi] = pending[rd_addr[gi]] & ~rd_hit;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, optional registered read,
// and a pending-write scoreboard for issue-time hazard tracking.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NRD       = 2,
  parameter int NWR       = 1,
  parameter int SYNC_READ = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     flush
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NRD-1:0]  busy_comb;

  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [XLEN-1:0] data_reg;
      logic [XLEN-1:0] data_next;

      // Ascending scan: the highest-indexed enabled port wins a collision.
      always_comb begin
        data_next = data_reg;
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_addr[k] == AW'(gi))) data_next = wr_data[k];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_reg <= '0;
        else        data_reg <= data_next;
      end

      assign regs[gi] = data_reg;
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [XLEN-1:0] data_comb;

      always_comb begin
        data_comb = regs[rd_addr[gi]];
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_addr[k] == rd_addr[gi]) && (rd_addr[gi] != '0))
            data_comb = wr_data[k];
        end
      end

      if (SYNC_READ != 0) begin : g_sync
        logic [XLEN-1:0] data_reg;
        logic            busy_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            data_reg <= data_comb;
            busy_reg <= busy_comb[gi];
          end
        end

        assign rd_data[gi] = data_reg;
        assign rd_busy[gi] = busy_reg;
      end else begin : g_comb
        // Gate with reset so a bypassed write cannot leak out while held in reset.
        assign rd_data[gi] = rst_n ? data_comb : '0;
        assign rd_busy[gi] = rst_n & busy_comb[gi];
      end
    end
  endgenerate

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .rd_busy  (busy_comb)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a combinational-read and a registered-read instance share
// stimulus and are checked every cycle against an array-based model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN  = XLEN_DEF;
  localparam int NREGS = NREGS_DEF;
  localparam int AW    = AW_DEF;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] c_rd_data, s_rd_data;
  logic [NRD-1:0]           c_rd_busy, s_rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     rsv_en;
  reg_idx_t                 rsv_addr;
  logic                     flush;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .SYNC_READ(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .SYNC_READ(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );

  // Architectural model: register contents and pending bits.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit wr_hits(input reg_idx_t a);
    bit h = 0;
    for (int k = 0; k < NWR; k++) if (wr_en[k] && wr_addr[k] == a) h = 1;
    return h;
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input reg_idx_t a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    for (int k = 0; k < NWR; k++) if (wr_en[k] && wr_addr[k] == a) v = wr_data[k];
    return v;
  endfunction

  function automatic logic exp_busy(input reg_idx_t a);
    return (a != 0) && m_pend[a] && !wr_hits(a);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 0;
    end
  endtask

  task automatic model_clock();
    bit hit [NREGS];
    for (int r = 0; r < NREGS; r++) hit[r] = wr_hits(reg_idx_t'(r));
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && wr_addr[k] != 0) m_regs[wr_addr[k]] = wr_data[k];
    for (int r = 1; r < NREGS; r++) begin
      if (flush)                                  m_pend[r] = 0;
      else if (rsv_en && rsv_addr == reg_idx_t'(r)) m_pend[r] = 1;
      else if (hit[r])                            m_pend[r] = 0;
    end
  endtask

  // One clock: drive at negedge, check comb outputs, clock the model, check registered outputs.
  task automatic step(input logic we0, input reg_idx_t wa0, input logic [XLEN-1:0] wd0,
                      input logic we1, input reg_idx_t wa1, input logic [XLEN-1:0] wd1,
                      input logic rsv, input reg_idx_t ra, input logic fl,
                      input reg_idx_t a0, input reg_idx_t a1,
                      output logic [XLEN-1:0] c0, output logic cb0,
                      output logic [XLEN-1:0] s0, output logic sb0);
    logic [XLEN-1:0] es_d [NRD];
    logic            es_b [NRD];
    @(negedge clk);
    wr_en = {we1, we0}; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    rsv_en = rsv; rsv_addr = ra; flush = fl;
    rd_addr = {a1, a0};
    #1;
    for (int j = 0; j < NRD; j++) begin
      es_d[j] = exp_read(rd_addr[j]);
      es_b[j] = exp_busy(rd_addr[j]);
      chk("comb_rd_data", c_rd_data[j], es_d[j]);
      chk("comb_rd_busy", {31'd0, c_rd_busy[j]}, {31'd0, es_b[j]});
    end
    c0 = c_rd_data[0]; cb0 = c_rd_busy[0];
    @(posedge clk);
    model_clock();
    #1;
    for (int j = 0; j < NRD; j++) begin
      chk("sync_rd_data", s_rd_data[j], es_d[j]);
      chk("sync_rd_busy", {31'd0, s_rd_busy[j]}, {31'd0, es_b[j]});
    end
    s0 = s_rd_data[0]; sb0 = s_rd_busy[0];
  endtask

  // Quiet read of current state on both ports through the combinational instance.
  task automatic peek(input reg_idx_t a, output logic [XLEN-1:0] d, output logic b);
    wr_en = '0; rsv_en = 1'b0; flush = 1'b0;
    rd_addr = {a, a};
    #1;
    chk("peek_rd_data", c_rd_data[0], exp_read(a));
    chk("peek_rd_busy", {31'd0, c_rd_busy[0]}, {31'd0, exp_busy(a)});
    d = c_rd_data[0]; b = c_rd_busy[0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] c0, s0, pd;
    logic cb0, sb0, pb;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    rd_addr = {5'd3, 5'd7};
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_comb_data", c_rd_data[0], 32'h0);
    chk("reset_sync_data", s_rd_data[1], 32'h0);
    chk("reset_sync_busy", {31'd0, s_rd_busy[0]}, 32'h0);
    rst_n = 1'b1;

    // Register 0 stays zero even when written.
    step(1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 5'd0, c0, cb0, s0, sb0);
    chk("x0_same_cycle", c0, 32'h0);
    peek(5'd0, pd, pb);
    chk("x0_after", pd, 32'h0);

    // Same-cycle write-first bypass.
    step(1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd5, 5'd0, c0, cb0, s0, sb0);
    chk("bypass_comb", c0, 32'h12345678);
    chk("bypass_sync", s0, 32'h12345678);

    // Write collision: port 1 wins.
    step(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 5'd0, 0, 5'd7, 5'd0, c0, cb0, s0, sb0);
    chk("collision_bypass", c0, 32'h22);
    peek(5'd7, pd, pb);
    chk("collision_stored", pd, 32'h22);

    // Reserve beats a same-cycle write; a later lone write clears.
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3, 5'd0, c0, cb0, s0, sb0);
    chk("rsv_not_yet_busy", {31'd0, cb0}, 32'h0);
    peek(5'd3, pd, pb);
    chk("rsv_busy", {31'd0, pb}, 32'h1);
    step(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3, 5'd0, c0, cb0, s0, sb0);
    peek(5'd3, pd, pb);
    chk("rsv_over_write", {31'd0, pb}, 32'h1);
    step(1, 5'd3, 32'h44, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd3, 5'd0, c0, cb0, s0, sb0);
    peek(5'd3, pd, pb);
    chk("write_clears", {31'd0, pb}, 32'h0);

    // Flush clears everything and overrides a same-cycle reserve.
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd4, 5'd9, c0, cb0, s0, sb0);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd4, 5'd9, c0, cb0, s0, sb0);
    chk("rsv4_busy", {31'd0, cb0}, 32'h1);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd10, 1, 5'd4, 5'd9, c0, cb0, s0, sb0);
    peek(5'd4, pd, pb);
    chk("flush_4", {31'd0, pb}, 32'h0);
    peek(5'd9, pd, pb);
    chk("flush_9", {31'd0, pb}, 32'h0);
    peek(5'd10, pd, pb);
    chk("flush_10", {31'd0, pb}, 32'h0);

    // Registered read with same-cycle write, then asynchronous reset mid-run.
    step(1, 5'd6, 32'hA5, 0, 5'd0, 32'h0, 1, 5'd6, 0, 5'd6, 5'd6, c0, cb0, s0, sb0);
    chk("sync_read_a5", s0, 32'hA5);
    rst_n = 1'b0;
    wr_en = '0; rsv_en = 1'b0; flush = 1'b0;
    model_reset();
    #1;
    chk("async_rst_sync_data", s_rd_data[0], 32'h0);
    chk("async_rst_comb_data", c_rd_data[0], 32'h0);
    chk("async_rst_sync_busy", {31'd0, s_rd_busy[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    peek(5'd6, pd, pb);
    chk("post_rst_reg6", pd, 32'h0);
    peek(5'd5, pd, pb);
    chk("post_rst_reg5", pd, 32'h0);

    // Randomized traffic; small address range to provoke collisions and hazards.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 11)), $urandom,
           1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 11)), $urandom,
           1'($urandom_range(0, 2) == 0), reg_idx_t'($urandom_range(0, 11)),
           1'($urandom_range(0, 15) == 0),
           reg_idx_t'($urandom_range(0, 11)), reg_idx_t'($urandom_range(0, 31)),
           c0, cb0, s0, sb0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
